// File: rtl/ldpc_pi_encoder.sv
// Systematic LDPC encoder: fetches the PI matrix row by row from the PI ROM server
// and builds codeword {parity, info}, one GF(2) parity bit per streamed row.
module ldpc_pi_encoder #(
  parameter int CodeLen      = 256,
  parameter int CodeLen_bits = 8,
  parameter int ChkLen       = 128,
  parameter int ChkLen_bits  = 7,
  localparam int InfoLen     = CodeLen - ChkLen
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               info_valid,
  output logic               info_ready,
  input  logic [InfoLen-1:0] info_in,
  output logic               encoder_read_PI_matrix,
  input  logic               PI_read_receive,
  input  logic               PI_valid,
  input  logic [CodeLen-1:0] dout_PI,
  output logic               code_valid,
  input  logic               code_ready,
  output logic [CodeLen-1:0] code_out,
  output logic               busy,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both 1; valid/data hold stable until then. PI_read_receive is a one-cycle ack.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, COLLECT = 2'd2, OUT = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [InfoLen-1:0]   info_q, info_d;
  logic [ChkLen-1:0]    parity_q, parity_d;
  logic [ChkLen_bits-1:0] row_q, row_d;
  logic                 req_q, req_d;
  logic                 cv_q, cv_d;
  logic [CodeLen-1:0]   code_q, code_d;

  // Upper PI row bits carry no information for this code.
  logic                    unused_pi_hi;
  logic [CodeLen_bits-1:0] unused_len;
  assign unused_pi_hi = ^dout_PI[CodeLen-1:InfoLen];
  assign unused_len   = CodeLen_bits'(CodeLen - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      info_q   <= '0;
      parity_q <= '0;
      row_q    <= '0;
      req_q    <= 1'b0;
      cv_q     <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      info_q   <= info_d;
      parity_q <= parity_d;
      row_q    <= row_d;
      req_q    <= req_d;
      cv_q     <= cv_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    info_d   = info_q;
    parity_d = parity_q;
    row_d    = row_q;
    req_d    = req_q;
    cv_d     = cv_q;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        if (info_valid) begin
          info_d   = info_in;
          parity_d = '0;
          row_d    = '0;
          req_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (PI_read_receive) begin
          req_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // Rows arrive in order; row i yields parity bit i.
        if (PI_valid) begin
          parity_d[row_q] = ^(dout_PI[InfoLen-1:0] & info_q);
          row_d           = row_q + ChkLen_bits'(1);
          if (row_q == ChkLen_bits'(ChkLen - 1)) begin
            cv_d    = 1'b1;
            code_d  = {parity_d, info_q};
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (code_ready) begin
          cv_d    = 1'b0;
          code_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rst gates info_ready so it reads 0 while reset is held.
  assign info_ready             = (state_q == IDLE) && rst;
  assign busy                   = (state_q != IDLE);
  assign encoder_read_PI_matrix = req_q;
  assign code_valid             = cv_q;
  assign code_out               = code_q;
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_ldpc_pi_encoder.sv
// Directed bench for ldpc_pi_encoder with a behavioural PI ROM server
// (1-cycle acknowledge, 2-cycle read latency, one trailing duplicate beat).
module tb_ldpc_pi_encoder;
  localparam int CL = 256;
  localparam int KL = 128;
  localparam int IL = CL - KL;

  logic          clk = 1'b0;
  logic          rst;
  logic          info_valid, info_ready;
  logic [IL-1:0] info_in;
  logic          enc_req, rcv, pi_valid;
  logic [CL-1:0] dout_pi;
  logic          code_valid, code_ready, busy;
  logic [CL-1:0] code_out;
  logic [1:0]    dbg_state;

  ldpc_pi_encoder dut (
    .clk(clk), .rst(rst),
    .info_valid(info_valid), .info_ready(info_ready), .info_in(info_in),
    .encoder_read_PI_matrix(enc_req), .PI_read_receive(rcv),
    .PI_valid(pi_valid), .dout_PI(dout_pi),
    .code_valid(code_valid), .code_ready(code_ready), .code_out(code_out),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [CL-1:0] rand_rows [KL];
  logic [CL-1:0] exp_q[$];

  typedef struct {
    int          mode;
    logic [IL-1:0] info;
    logic [IL-1:0] exp_par;
    int          hold;
  } vec_t;
  vec_t vecs [6];

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // mode 0 identity, 1 random, 2 row i has popcount i (upper ones), 3 identity (upper ones)
  function automatic logic [CL-1:0] row_of(input int mode, input int i);
    logic [IL-1:0] one;
    one = 1;
    case (mode)
      0:       return {{IL{1'b0}}, one << i};
      1:       return rand_rows[i];
      2:       return {{IL{1'b1}}, (one << i) - one};
      default: return {{IL{1'b1}}, one << i};
    endcase
  endfunction

  function automatic logic [IL-1:0] golden(input int mode, input logic [IL-1:0] info);
    logic [IL-1:0] p;
    logic [CL-1:0] r;
    for (int i = 0; i < KL; i++) begin
      r    = row_of(mode, i);
      p[i] = ^(r[IL-1:0] & info);
    end
    return p;
  endfunction

  // driver: offer a word; returns at the negedge after acceptance
  task automatic start_word(input logic [IL-1:0] info);
    int n;
    n = 0;
    info_valid = 1'b1;
    info_in    = info;
    while (!info_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk1("accept_timeout", (n < 300), 1'b1);
    @(negedge clk);
    info_valid = 1'b0;
    chk1("req_rise", enc_req, 1'b1);
    chk1("busy_rise", busy, 1'b1);
  endtask

  // ROM server model, entered at the negedge right after acceptance
  task automatic serve_rom(input int mode, input int nrows, input bit trailing);
    @(negedge clk);
    rcv      = 1'b1;
    pi_valid = 1'b1;          // stray beat during REQ must be ignored
    dout_pi  = '1;
    chk1("req_hold", enc_req, 1'b1);
    @(negedge clk);
    rcv      = 1'b0;
    pi_valid = 1'b0;
    chk1("req_drop", enc_req, 1'b0);
    @(negedge clk);
    for (int i = 0; i < nrows; i++) begin
      pi_valid = 1'b1;
      dout_pi  = row_of(mode, i);
      if (i == KL - 1) chk1("cv_not_early", code_valid, 1'b0);
      @(negedge clk);
    end
    pi_valid = 1'b0;
    if (trailing) begin
      pi_valid = 1'b1;
      dout_pi  = '1;
    end
  endtask

  // scoreboard: check the codeword, hold off code_ready, then hand it off
  task automatic finish_word(input int hold);
    logic [CL-1:0] exp;
    chk1("exp_q_nonempty", (exp_q.size() > 0), 1'b1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk1("cv_rise", code_valid, 1'b1);
    chkw("code_out", code_out, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      pi_valid = 1'b0;
      chk1("bp_cv_hold", code_valid, 1'b1);
      chkw("bp_code_hold", code_out, exp);
      chk1("bp_ready_low", info_ready, 1'b0);
      chk1("bp_no_req", enc_req, 1'b0);
      info_valid = 1'b1;
      info_in    = ~exp[IL-1:0];
      rcv        = h[0];
    end
    info_valid = 1'b0;
    rcv        = 1'b0;
    code_ready = 1'b1;
    @(negedge clk);
    pi_valid   = 1'b0;
    code_ready = 1'b0;
    chk1("cv_drop", code_valid, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_ready", info_ready, 1'b1);
    chk1("no_early_req", enc_req, 1'b0);
  endtask

  initial begin
    logic [IL-1:0] w1, w2, w3;
    rst = 1'b0; info_valid = 1'b0; info_in = '0; rcv = 1'b0;
    pi_valid = 1'b0; dout_pi = '0; code_ready = 1'b0;
    #1;
    chk1("rst_info_ready", info_ready, 1'b0);
    chk1("rst_req", enc_req, 1'b0);
    chk1("rst_cv", code_valid, 1'b0);
    chkw("rst_code", code_out, '0);
    chk1("rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("rel_info_ready", info_ready, 1'b1);
    chk1("rel_busy", busy, 1'b0);
    chkw("rel_state", CL'(dbg_state), '0);
    @(negedge clk);

    for (int i = 0; i < KL; i++)
      rand_rows[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

    vecs[0] = '{mode: 0, info: {16{8'hA5}}, exp_par: {16{8'hA5}}, hold: 20};
    vecs[1] = '{mode: 0, info: 128'h0123456789ABCDEF_FEDCBA9876543210,
                exp_par: 128'h0123456789ABCDEF_FEDCBA9876543210, hold: 0};
    vecs[2] = '{mode: 1, info: '0, exp_par: '0, hold: 3};
    vecs[3] = '{mode: 2, info: '1, exp_par: {32{4'hA}}, hold: 0};
    vecs[4] = '{mode: 2, info: 128'h1, exp_par: {{127{1'b1}}, 1'b0}, hold: 0};
    vecs[5] = '{mode: 3, info: 128'hDEADBEEF_00000000_CAFEF00D_12345678,
                exp_par: 128'hDEADBEEF_00000000_CAFEF00D_12345678, hold: 1};

    for (int v = 0; v < 6; v++) begin
      exp_q.push_back({vecs[v].exp_par, vecs[v].info});
      start_word(vecs[v].info);
      serve_rom(vecs[v].mode, KL, 1'b0);
      finish_word(vecs[v].hold);
    end

    // trailing all-ones beat, then a back-to-back second word
    w1 = {$urandom, $urandom, $urandom, $urandom};
    w2 = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back({golden(1, w1), w1});
    start_word(w1);
    serve_rom(1, KL, 1'b1);
    finish_word(0);
    exp_q.push_back({golden(1, w2), w2});
    start_word(w2);
    serve_rom(1, KL, 1'b1);
    finish_word(0);

    // reset after 60 rows, then a clean encode
    w3 = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;
    start_word(w3);
    serve_rom(0, 60, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk1("mid_rst_req", enc_req, 1'b0);
    chk1("mid_rst_cv", code_valid, 1'b0);
    chkw("mid_rst_code", code_out, '0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ready", info_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back({w3, w3});
    start_word(w3);
    serve_rom(0, KL, 1'b1);
    finish_word(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldpc_pi_encoder.md
# ldpc_pi_encoder

Systematic LDPC encoder core. It accepts an InfoLen-bit information word and requests the PI parity-generation matrix from the PI ROM server. It consumes the ChkLen streamed matrix rows and computes one parity bit per row, then presents the CodeLen-bit codeword downstream. It is the requesting and consuming end of the PI ROM read protocol.

## Interface
- CodeLen, 256, codeword length
- CodeLen_bits, 8, bits to address CodeLen
- ChkLen, 128, parity bits, equal to the number of PI rows
- ChkLen_bits, 7, row counter width
- InfoLen (derived, not overridable), CodeLen-ChkLen = 128, information bits

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- info_valid  in  1  information word offered
- info_ready  out  1  encoder can accept a word
- info_in  in  InfoLen  information bits
- encoder_read_PI_matrix  out  1  read request to the PI ROM server
- PI_read_receive  in  1  single-cycle request acknowledge from the ROM server
- PI_valid  in  1  dout_PI carries a valid PI row this cycle
- dout_PI  in  CodeLen  PI row; bits [InfoLen-1:0] are used, upper bits are ignored
- code_valid  out  1  codeword available
- code_ready  in  1  downstream accepts the codeword
- code_out  out  CodeLen  codeword {parity, info}
- busy  out  1  high in every state except IDLE

## Operation
- FSM states are IDLE, REQ, COLLECT and OUT. Outputs are registered.
- IDLE
  - info_ready=1.
  - On info_valid&info_ready: latch info_in into info_reg, clear parity_reg and row_cnt, set encoder_read_PI_matrix<=1, go to REQ.
- REQ
  - Hold the request high until PI_read_receive is sampled 1.
  - Then drop the request and go to COLLECT.
  - PI_valid is ignored in REQ.
- COLLECT
  - On each PI_valid: parity_reg[row_cnt] <= ^(dout_PI[InfoLen-1:0] & info_reg), and row_cnt increments.
  - On the beat where row_cnt==ChkLen-1: set code_valid<=1 and go to OUT.
  - Row i maps to parity bit i in strict arrival order.
- OUT
  - code_out = {parity_reg, info_reg}: code_out[InfoLen-1:0]=info, code_out[InfoLen+i]=p[i].
  - code_valid and code_out are held stable until code_ready is sampled 1. Then code_valid<=0 and the FSM goes to IDLE.
  - PI_valid is ignored in OUT. The ROM server emits one trailing duplicate beat (ChkLen+1 total), and it must not corrupt parity or state.
- Parity uses GF(2) arithmetic: AND then XOR-reduce over InfoLen bits. No carries.
- Reset values: info_ready=0 during reset (1 after release in IDLE), encoder_read_PI_matrix=0, code_valid=0, code_out=0, busy=0. State=IDLE, row_cnt=0, info_reg=0, parity_reg=0.
- Reset mid-operation aborts the codeword and drops the request immediately. No partial codeword is ever emitted.
- PI_read_receive seen outside REQ is ignored.

## Timing
- info_ready is combinational from state (IDLE only), so a word is accepted in the first IDLE cycle.
- With the PI ROM server (1-cycle acknowledge, 2-cycle read latency), counting from acceptance at edge 0:
  - request is high from edge 0;
  - receive is sampled at edge 2 and the request drops;
  - PI_valid beats are sampled at edges 4..4+ChkLen-1;
  - code_valid rises at edge 4+ChkLen-1 (edge 131 at the defaults).
- A codeword is accepted at the first edge where code_valid&code_ready. The next info word can be accepted the cycle after that.
- Minimum spacing between info accepts is ChkLen+5 cycles.
- The request is never reissued before the previous codeword leaves OUT. By then the ROM server has returned to idle and its trailing beat has passed.
- There is no timeout. If PI_valid stalls, the block waits indefinitely in COLLECT.

## Test plan
- Reset: assert rst=0 mid-cycle -> all outputs 0 asynchronously. After release: info_ready=1, busy=0.
- Identity PI: row i = 1<<i, info=128'hA5A5...A5 -> parity equals info, code_out={info,info}, code_valid at edge 131 after accept.
- Zero info with random PI rows -> parity all 0. All-ones info with row i having popcount i -> p[i]=i&1. Upper dout_PI bits set to 1 have no effect.
- Backpressure: code_ready=0 for 20 cycles -> code_valid and code_out stable. info_ready stays 0 and no request is issued. The handshake on the 21st cycle returns to IDLE.
- Trailing 129th PI_valid beat carrying all-ones, followed by back-to-back words -> first codeword unaffected. The second codeword matches the golden model, and the second request rises only after the first codeword handshake.
- Reset asserted after 60 rows are collected -> request=0 and code_valid=0. A fresh encode after release produces the correct codeword.
